// File: rtl/pipelined_write_sched.sv
// pipelined_write_sched: round-robin scheduler serializing pipelined writes onto one lane
// Optional even-parity output wr_par enabled by defining PIPELINED_WRITE_SCHED_PARITY_EN.
module pipelined_write_sched #(
    parameter int NUM_REQ       = 4,
    parameter int MAX_WR_CYCLES = 4,
    parameter int WR_WIDTH      = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_REQ-1:0]                      req_vld,
    input  logic [NUM_REQ*5*(WR_WIDTH+2)-1:0]       req_wr,
    output logic [NUM_REQ-1:0]                      req_rdy,
    output logic                                    wr_vld,
    output logic [WR_WIDTH+1:0]                     wr_bus,
    input  logic                                    wr_stall,
    output logic [NUM_REQ-1:0]                      wdone,
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
    output logic                                    wr_par,
`endif
    output logic                                    busy
);
    localparam int BW = WR_WIDTH + 2;
    localparam int PW = 5 * BW;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {WT_STD = 2'd0, WT_MULTI = 2'd1, WT_SINGLE = 2'd2, WT_ILLEGAL = 2'd3} write_type_e;
    typedef enum logic [1:0] {CT_IDLE = 2'd0, CT_VALID = 2'd1, CT_DONE = 2'd2, CT_RSVD = 2'd3} cycle_type_e;
    typedef struct packed {
        logic              vld;
        write_type_e       write_type;
        logic [1:0]        num_cycles;
        logic [BW-6:0]     addr;
    } write_cmd_t;
    typedef struct packed {
        cycle_type_e       cycle_type;
        logic [WR_WIDTH-1:0] dat;
    } write_data_t;
    typedef struct packed {
        write_cmd_t        cmd;
        write_data_t [3:0] dat;
    } pipelined_write_t;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

    state_e           state_q, state_d;
    pipelined_write_t wr_q, wr_d;
    logic [IW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d, win;
    logic [1:0]       beat_q, beat_d;
    logic             wr_vld_q, wr_vld_d;
    logic [BW-1:0]    wr_bus_q, wr_bus_d;
    logic [NUM_REQ-1:0] wdone_q, wdone_d;
    logic             any, acc, last;
    logic [2:0]       n;
    pipelined_write_t grant_wr;
    write_cmd_t       gcmd;

    // Data beat with its cycle_type rewritten to VALID, or DONE on the final beat.
    function automatic write_data_t beat_word(input pipelined_write_t w, input logic [1:0] b, input logic l);
        return write_data_t'{cycle_type: l ? CT_DONE : CT_VALID, dat: w.dat[b].dat};
    endfunction

    // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
    always_comb begin
        win = '0;
        any = |req_vld;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req_vld[(int'(rr_ptr_q) + k) % NUM_REQ]) win = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
    end

    assign acc      = wr_vld_q & ~wr_stall;
    assign n        = (wr_q.cmd.num_cycles == 2'd0) ? 3'(MAX_WR_CYCLES) : {1'b0, wr_q.cmd.num_cycles};
    assign last     = ({1'b0, beat_q} == n - 3'd1);
    assign grant_wr = pipelined_write_t'(req_wr[int'(win) * PW +: PW]);
    assign req_rdy  = (state_q == IDLE && any && !rst) ? NUM_REQ'(1) << win : '0;

    // Next-state and lane/wdone updates for the grant -> cmd -> data sequence.
    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        beat_d   = beat_q;
        wr_vld_d = wr_vld_q;
        wr_bus_d = wr_bus_q;
        wdone_d  = '0;
        gcmd     = grant_wr.cmd;
        gcmd.vld = 1'b1;
        case (state_q)
            IDLE: if (any) begin
                state_d  = CMD;
                wr_d     = grant_wr;
                owner_d  = win;
                rr_ptr_d = IW'((int'(win) + 1) % NUM_REQ);
                wr_vld_d = 1'b1;
                wr_bus_d = gcmd;
            end
            CMD: if (acc) begin
                state_d  = DATA;
                beat_d   = 2'd0;
                wr_bus_d = beat_word(wr_q, 2'd0, n == 3'd1);
            end
            DATA: if (acc) begin
                wdone_d  = (wr_q.cmd.write_type == WT_MULTI || (wr_q.cmd.write_type == WT_SINGLE && last))
                           ? NUM_REQ'(1) << owner_q : '0;
                state_d  = last ? IDLE : DATA;
                beat_d   = beat_q + 2'd1;
                wr_vld_d = !last;
                wr_bus_d = last ? '0 : beat_word(wr_q, beat_q + 2'd1, {1'b0, beat_q} + 3'd1 == n - 3'd1);
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            wr_vld_q <= 1'b0;
            wr_bus_q <= '0;
            wdone_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            beat_q   <= beat_d;
            wr_vld_q <= wr_vld_d;
            wr_bus_q <= wr_bus_d;
            wdone_q  <= wdone_d;
        end
    end

    assign wr_vld = wr_vld_q;
    assign wr_bus = wr_bus_q;
    assign wdone  = wdone_q;
    assign busy   = state_q != IDLE;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
    assign wr_par = ^wr_bus_q;
`endif
endmodule

// File: tb/tb_pipelined_write_sched.sv
// tb_pipelined_write_sched: scoreboard bench for the round-robin pipelined write scheduler
module tb_pipelined_write_sched;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_vld;
    logic [199:0] req_wr;
    logic [3:0]   req_rdy;
    logic         wr_vld;
    logic [9:0]   wr_bus;
    logic         wr_stall;
    logic [3:0]   wdone;
    logic         busy;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
    logic         wr_par;
`endif
    logic [49:0]  tb_wr [4];

    typedef struct {
        logic [9:0] bus;
        logic [3:0] wd;
    } beat_t;

    beat_t       sbq[$];
    int          glog[$];
    int          passed = 0, total = 0;
    int          m_rr = 0, acc_n = 0, drop_idx = 0;
    int          wd_cnt[4] = '{0, 0, 0, 0};
    logic [3:0]  pend_wd = '0;

    pipelined_write_sched dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_wr(req_wr), .req_rdy(req_rdy),
        .wr_vld(wr_vld), .wr_bus(wr_bus), .wr_stall(wr_stall), .wdone(wdone),
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
        .wr_par(wr_par),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    assign req_wr = {tb_wr[3], tb_wr[2], tb_wr[1], tb_wr[0]};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [49:0] mk(input logic [1:0] wt, input logic [1:0] nc, input logic [4:0] addr,
                                       input logic [7:0] d0, input logic [7:0] d1,
                                       input logic [7:0] d2, input logic [7:0] d3);
        return {1'b0, wt, nc, addr, 2'b11, d3, 2'b11, d2, 2'b11, d1, 2'b11, d0};
    endfunction

    function automatic int pick();
        for (int k = 0; k < 4; k++)
            if (req_vld[(m_rr + k) % 4]) return (m_rr + k) % 4;
        return -1;
    endfunction

    task automatic push_write(input int g);
        logic [49:0] w;
        int          nn;
        beat_t       e;
        w = tb_wr[g];
        e.bus = w[49:40] | 10'h200;
        e.wd = 4'h0;
        sbq.push_back(e);
        nn = (w[46:45] == 2'd0) ? 4 : int'(w[46:45]);
        for (int b = 0; b < nn; b++) begin
            e.bus = {(b == nn - 1) ? 2'b10 : 2'b01, w[10*b +: 8]};
            e.wd = (w[48:47] == 2'd1 || (w[48:47] == 2'd2 && b == nn - 1)) ? 4'(1 << g) : 4'h0;
            sbq.push_back(e);
        end
    endtask

    // One clock: scoreboard sampling at negedge, input updates just after posedge.
    task automatic step();
        logic [3:0] exp_rdy;
        int         w;
        @(negedge clk);
        if (rst) begin
            sbq.delete();
            m_rr = 0;
            pend_wd = '0;
        end else begin
            for (int i = 0; i < 4; i++) if (wdone[i]) wd_cnt[i]++;
            total++;
            if (wdone !== pend_wd) $display("FAIL wdone: got %b expected %b at %0t", wdone, pend_wd, $time);
            else passed++;
            pend_wd = '0;
            total++;
            if (wr_vld !== (sbq.size() != 0) || busy !== (sbq.size() != 0))
                $display("FAIL vld_busy: wr_vld=%b busy=%b expected %b at %0t", wr_vld, busy, sbq.size() != 0, $time);
            else passed++;
            exp_rdy = '0;
            w = -1;
            if (sbq.size() == 0) begin
                w = pick();
                if (w >= 0) exp_rdy = 4'(1 << w);
            end
            total++;
            if (req_rdy !== exp_rdy) $display("FAIL req_rdy: got %b expected %b at %0t", req_rdy, exp_rdy, $time);
            else passed++;
            if (sbq.size() != 0) begin
                total++;
                if (wr_bus !== sbq[0].bus) $display("FAIL wr_bus: got %h expected %h at %0t", wr_bus, sbq[0].bus, $time);
                else passed++;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
                total++;
                if (wr_par !== ^sbq[0].bus) $display("FAIL wr_par: got %b expected %b", wr_par, ^sbq[0].bus);
                else passed++;
`endif
                if (!wr_stall) begin
                    pend_wd = sbq[0].wd;
                    void'(sbq.pop_front());
                    acc_n++;
                end
            end
            if (w >= 0) begin
                push_write(w);
                glog.push_back(w);
                m_rr = (w + 1) % 4;
            end
        end
        @(posedge clk);
        #2;
        while (drop_idx < glog.size()) begin
            req_vld[glog[drop_idx]] = 1'b0;
            drop_idx++;
        end
    endtask

    task automatic wait_idle(input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            if (sbq.size() == 0 && req_vld == 4'h0 && pend_wd == 4'h0 && !busy) break;
            step();
        end
        total++;
        if (i == 200) $display("FAIL %s_timeout: queue %0d entries left, required 0", nm, sbq.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_vld = '0;
        wr_stall = 1'b0;
        for (int i = 0; i < 4; i++) tb_wr[i] = '0;
        step();
        step();
        total++;
        if ({req_rdy, wr_vld, wr_bus, wdone, busy} !== 20'h0)
            $display("FAIL reset_outputs: got rdy=%b vld=%b bus=%h wdone=%b busy=%b required all 0",
                     req_rdy, wr_vld, wr_bus, wdone, busy);
        else passed++;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
        total++;
        if (wr_par !== 1'b0) $display("FAIL reset_par: got %b required 0", wr_par);
        else passed++;
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        int b0 = acc_n, g0 = glog.size(), w0 = wd_cnt[0];
        tb_wr[0] = mk(2'd0, 2'd2, 5'h05, 8'hA5, 8'h3C, 8'h00, 8'h00);
        req_vld[0] = 1'b1;
        wait_idle("single");
        total++;
        if (glog.size() != g0 + 1 || glog[g0] != 0) $display("FAIL single_grant: got %0d grants required one to req0", glog.size() - g0);
        else passed++;
        total++;
        if (acc_n - b0 != 3) $display("FAIL single_beats: got %0d required 3", acc_n - b0);
        else passed++;
        total++;
        if (wd_cnt[0] != w0) $display("FAIL single_wdone: got %0d pulses required 0", wd_cnt[0] - w0);
        else passed++;
    endtask

    task automatic test_multi();
        int b0 = acc_n, w0 = wd_cnt[2];
        tb_wr[2] = mk(2'd1, 2'd0, 5'h12, 8'h11, 8'h22, 8'h33, 8'h44);
        req_vld[2] = 1'b1;
        wait_idle("multi");
        total++;
        if (acc_n - b0 != 5) $display("FAIL multi_beats: got %0d required 5", acc_n - b0);
        else passed++;
        total++;
        if (wd_cnt[2] - w0 != 4) $display("FAIL multi_wdone: got %0d required 4", wd_cnt[2] - w0);
        else passed++;
    endtask

    task automatic test_round_robin();
        int g0, w0[4];
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        g0 = glog.size();
        for (int i = 0; i < 4; i++) w0[i] = wd_cnt[i];
        for (int i = 0; i < 4; i++)
            tb_wr[i] = mk(2'd2, 2'(i), 5'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i));
        req_vld = 4'hF;
        wait_idle("rr_all");
        req_vld = 4'b0011;
        wait_idle("rr_again");
        for (int i = 0; i < 6; i++) begin
            total++;
            if (glog.size() <= g0 + i || glog[g0 + i] != i % 4)
                $display("FAIL rr_order%0d: got %0d required %0d", i, glog.size() > g0 + i ? glog[g0 + i] : -1, i % 4);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wd_cnt[i] - w0[i] != (i < 2 ? 2 : 1))
                $display("FAIL rr_wdone%0d: got %0d required %0d", i, wd_cnt[i] - w0[i], i < 2 ? 2 : 1);
            else passed++;
        end
    endtask

    task automatic test_stall();
        int         b0 = acc_n, i;
        logic [9:0] snap;
        tb_wr[1] = mk(2'd1, 2'd3, 5'h07, 8'h5A, 8'hC3, 8'h7E, 8'h00);
        req_vld[1] = 1'b1;
        for (i = 0; i < 50 && acc_n - b0 < 2; i++) step();
        total++;
        if (acc_n - b0 != 2) $display("FAIL stall_reach: got %0d beats required 2", acc_n - b0);
        else passed++;
        wr_stall = 1'b1;
        snap = wr_bus;
        total++;
        if (snap !== 10'h1C3) $display("FAIL stall_beat1: got %h required 1c3", snap);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (wr_bus !== snap || wr_vld !== 1'b1) $display("FAIL stall_hold%0d: got %h/%b required %h/1", k, wr_bus, wr_vld, snap);
            else passed++;
        end
        wr_stall = 1'b0;
        wait_idle("stall");
        total++;
        if (acc_n - b0 != 4) $display("FAIL stall_beats: got %0d required 4", acc_n - b0);
        else passed++;
    endtask

    task automatic test_parity();
        int w0 = wd_cnt[0];
        tb_wr[0] = mk(2'd3, 2'd3, 5'h1F, 8'h00, 8'h01, 8'h03, 8'h00);
        tb_wr[0][49] = 1'b1;
        req_vld[0] = 1'b1;
        step();
        total++;
        if (wr_bus !== 10'h3FF) $display("FAIL par_cmd: got %h required 3ff", wr_bus);
        else passed++;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
        total++;
        if (wr_par !== 1'b0) $display("FAIL par_cmd_bit: got %b required 0", wr_par);
        else passed++;
`endif
        step();
        total++;
        if (wr_bus !== 10'h100) $display("FAIL par_data: got %h required 100", wr_bus);
        else passed++;
`ifdef PIPELINED_WRITE_SCHED_PARITY_EN
        total++;
        if (wr_par !== 1'b1) $display("FAIL par_data_bit: got %b required 1", wr_par);
        else passed++;
`endif
        wait_idle("parity");
        total++;
        if (wd_cnt[0] != w0) $display("FAIL illegal_type_wdone: got %0d required 0", wd_cnt[0] - w0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int b0 = acc_n, g0, w1 = wd_cnt[1], w3 = wd_cnt[3];
        tb_wr[1] = mk(2'd2, 2'd0, 5'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
        req_vld[1] = 1'b1;
        for (int i = 0; i < 50 && acc_n - b0 < 3; i++) step();
        total++;
        if (wr_bus !== 10'h1BE) $display("FAIL rstmid_beat2: got %h required 1be", wr_bus);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({req_rdy, wr_vld, wr_bus, wdone, busy} !== 20'h0)
            $display("FAIL rstmid_outputs: got rdy=%b vld=%b bus=%h wdone=%b busy=%b required all 0",
                     req_rdy, wr_vld, wr_bus, wdone, busy);
        else passed++;
        step();
        step();
        rst = 1'b0;
        g0 = glog.size();
        tb_wr[3] = mk(2'd2, 2'd1, 5'h09, 8'h77, 8'h00, 8'h00, 8'h00);
        req_vld[3] = 1'b1;
        wait_idle("rstmid");
        total++;
        if (glog.size() != g0 + 1 || glog[g0] != 3) $display("FAIL rstmid_grant: got %0d grants required one to req3", glog.size() - g0);
        else passed++;
        total++;
        if (wd_cnt[1] != w1 || wd_cnt[3] - w3 != 1)
            $display("FAIL rstmid_wdone: got req1=%0d req3=%0d required 0 and 1", wd_cnt[1] - w1, wd_cnt[3] - w3);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_round_robin();
        test_stall();
        test_parity();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
